// File: rtl/fsqrt_issue.sv
// fsqrt_issue: credit-based issue/return wrapper for an external 3-stage square-root datapath.
// Optional FSQRT_NEG_NAN_EN replaces results of negative nonzero operands with a quiet NaN.
module fsqrt_issue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sq_x,
  input  logic [31:0]      sq_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);
  logic [3:0] vld;
  logic [3:0][TAG_W-1:0] tg;
  logic [AW:0] wr_ptr, rd_ptr, occ;
  logic [31:0] y_mem [DEPTH];
  logic [TAG_W-1:0] t_mem [DEPTH];
  logic [2:0] in_flight;
  logic [AW+1:0] credits;
  logic [31:0] push_y;
  logic acc, push, pop, full;
  assign acc = in_valid && in_ready;
  assign push = vld[3];
  assign pop = out_valid && out_ready;
  assign occ = wr_ptr - rd_ptr;
  assign full = occ[AW];
  assign in_flight = {2'b0, vld[0]} + {2'b0, vld[1]} + {2'b0, vld[2]} + {2'b0, vld[3]};
  assign credits = {{(AW-1){1'b0}}, in_flight} + {1'b0, occ};
  assign in_ready = credits < DEPTH_C;
  assign out_valid = wr_ptr != rd_ptr;
  assign out_y = out_valid ? y_mem[rd_ptr[AW-1:0]] : '0;
  assign out_tag = out_valid ? t_mem[rd_ptr[AW-1:0]] : '0;
  assign busy = |vld || out_valid;
`ifdef FSQRT_NEG_NAN_EN
  logic [3:0] neg;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) neg <= '0;
    else neg <= {neg[2:0], acc && in_x[31] && |in_x[30:0]};
  assign push_y = neg[3] ? 32'h7FC00000 : sq_y;
`else
  assign push_y = sq_y;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      vld <= '0;
      tg <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      sq_x <= '0;
    end else begin
      vld <= {vld[2:0], acc};
      tg <= {tg[2:0], in_tag};
      if (acc) sq_x <= in_x;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      y_mem[wr_ptr[AW-1:0]] <= push_y;
      t_mem[wr_ptr[AW-1:0]] <= tg[3];
    end
  assert property (@(posedge clk) disable iff (!rstn) !(push && full));
endmodule
